// File: rtl/alu_div_ctrl_pkg.sv
// Shared constants for the restoring-division controller and its datapath.
package alu_div_ctrl_pkg;

  // Operand width; fixed at 4 because the shared alu is a 4-bit unit.
  localparam int W     = 4;
  // Iteration counter width, log2(W).
  localparam int CNT_W = 2;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [W-1:0] DBZ_QUOTIENT = 4'hF;

  // Counter load value: W trial subtractions, counted down to zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);

endpackage

// File: rtl/alu_div_ctrl_alu.sv
// Shared 4-bit add/sub datapath. ci=1 selects subtract (a - b); co is then
// the inverted borrow, i.e. co=1 means a >= b.
module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] w_sum;

  // Two's-complement subtract folds into the adder by inverting b and
  // feeding ci in as the +1.
  always_comb begin
    w_sum = {1'b0, a} + {1'b0, b ^ {4{ci}}} + {4'b0000, ci};
  end

  assign s  = w_sum[3:0];
  assign co = w_sum[4];

endmodule

// File: rtl/alu_div_ctrl.sv
// Unsigned 4-bit divider controller. Sequences the shared alu through one
// non-performing restoring step per cycle and registers the results.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured on acceptance
// ITER    | one quotient bit per cycle, W cycles, counter runs 3..0
// DONE    | one-cycle done pulse; results already in output registers
module alu_div_ctrl
  import alu_div_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_dvs;
  logic [W-1:0]     r_quotient;
  logic [W-1:0]     r_remainder;
  logic             r_div_by_zero;

  logic [W-1:0]     w_low;
  logic [W-1:0]     w_alu_a;
  logic [W-1:0]     w_alu_b;
  logic             w_alu_ci;
  logic [W-1:0]     w_alu_s;
  logic             w_alu_co;
  logic             w_qbit;
  logic [W-1:0]     w_rem_next;
  logic [W-1:0]     w_quo_next;

  // Low W bits of the shifted partial remainder; its 5th bit is r_rem[W-1].
  assign w_low = {r_rem[W-2:0], r_quo[W-1]};

  // Drive the alu only while iterating; park it at zero otherwise.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_ci = 1'b0;
    if (r_state == ST_ITER) begin
      w_alu_a  = w_low;
      w_alu_b  = r_dvs;
      w_alu_ci = 1'b1;
    end
  end

  alu u_alu (
    .a  (w_alu_a),
    .b  (w_alu_b),
    .ci (w_alu_ci),
    .s  (w_alu_s),
    .co (w_alu_co)
  );

  // The 5-bit partial remainder is >= divisor iff its MSB is set or the
  // 4-bit subtraction did not borrow; in that case keep the difference.
  always_comb begin
    w_qbit     = r_rem[W-1] | w_alu_co;
    w_rem_next = w_qbit ? w_alu_s : w_low;
    w_quo_next = {r_quo[W-2:0], w_qbit};
  end

  // FSM, iteration counter and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
            r_cnt <= CNT_LOAD;
            r_state <= (divisor == '0) ? ST_DONE : ST_ITER;
          end
        end
        ST_ITER: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result registers load on the edge that enters DONE, so they are valid
  // together with done and hold until the next division completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (r_state == ST_IDLE && start && divisor == '0) begin
      r_quotient    <= DBZ_QUOTIENT;
      r_remainder   <= dividend;
      r_div_by_zero <= 1'b1;
    end else if (r_state == ST_ITER && r_cnt == '0) begin
      r_quotient    <= w_quo_next;
      r_remainder   <= w_rem_next;
      r_div_by_zero <= 1'b0;
    end
  end

  assign busy        = (r_state == ST_ITER) || (r_state == ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Self-checking bench for alu_div_ctrl: a transaction-level model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_alu_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a division occupies 5 busy cycles (1 if divisor is zero); the
  // last busy cycle is the done cycle, when results become visible.
  int         m_left;
  logic [3:0] m_q, m_r, p_q, p_r;
  logic       m_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_q <= 4'd0; m_r <= 4'd0; m_z <= 1'b0;
      p_q <= 4'd0; p_r <= 4'd0;
    end else if (m_left == 0) begin
      if (start) begin
        if (divisor == 4'd0) begin
          m_left <= 1;
          m_q <= 4'hF; m_r <= dividend; m_z <= 1'b1;
        end else begin
          m_left <= 5;
          p_q <= dividend / divisor;
          p_r <= dividend % divisor;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_q <= p_q; m_r <= p_r; m_z <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_left != 0);
    check("done", done, m_left == 1);
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", div_by_zero, m_z);
  end

  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic ez, input int elat, input string tag);
    int cycles;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 12) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, " latency"}, cycles, elat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " dbz"}, div_by_zero, ez);
  endtask

  logic [3:0] v_a [12] = '{4'd13, 4'd15, 4'd7, 4'd15, 4'd6, 4'd9,  4'd8, 4'd12, 4'd0, 4'd15, 4'd3,  4'd11};
  logic [3:0] v_b [12] = '{4'd3,  4'd8,  4'd9, 4'd1,  4'd6, 4'd0,  4'd2, 4'd5,  4'd7, 4'd15, 4'd14, 4'd2};
  logic [3:0] v_q [12] = '{4'd4,  4'd1,  4'd0, 4'd15, 4'd1, 4'hF,  4'd4, 4'd2,  4'd0, 4'd1,  4'd0,  4'd5};
  logic [3:0] v_r [12] = '{4'd1,  4'd7,  4'd7, 4'd0,  4'd0, 4'd9,  4'd0, 4'd2,  4'd0, 4'd0,  4'd3,  4'd1};
  logic       v_z [12] = '{1'b0,  1'b0,  1'b0, 1'b0,  1'b0, 1'b1,  1'b0, 1'b0,  1'b0, 1'b0,  1'b0,  1'b0};

  initial begin
    int cycles;
    int n_done;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_div(v_a[i], v_b[i], v_q[i], v_r[i], v_z[i], v_z[i] ? 1 : 5, $sformatf("vec%0d", i));
    end

    // Start and operand changes while busy are ignored.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(negedge clk);
    start = 1'b0; dividend = 4'd7; divisor = 4'd0;
    cycles = 2;
    while (!done && cycles < 12) begin
      @(negedge clk);
      cycles++;
    end
    check("busy-start latency", cycles, 5);
    check("busy-start quotient", quotient, 4);
    check("busy-start remainder", remainder, 1);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy-start extra done", n_done, 0);

    // Start held high is re-accepted right after DONE.
    @(negedge clk);
    start = 1'b1; dividend = 4'd10; divisor = 4'd3;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    check("held-start done count", n_done, 2);
    check("held-start quotient", quotient, 3);
    check("held-start remainder", remainder, 1);
    repeat (3) @(negedge clk);

    // Reset in the second ITER cycle aborts without a done.
    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "pre-reset");
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", div_by_zero, 0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort done seen", n_done, 0);
    #2 rst_n = 1'b1;
    run_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 5, "post-reset");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
